mem_stage_req_ctrl: RTL and testbench

- Memory-stage initiator that turns the EX/M latch's load/store request into a held dmemREN/dmemWEN handshake toward the datapath cache interface.
- Waits for dhit, captures load data, and presents dmemLoad plus a one-cycle dHit to the M/WB latch.
- Stalls the upstream pipeline while an access is outstanding.
- Handles flush and halt so the M/WB latch never sees a squashed or post-halt access.

---
 rtl/mem_stage_req_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem_stage_req_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_req_ctrl.sv
// mem_stage_req_ctrl: memory-stage initiator. Converts the EX/M load/store
// request into a held dmemREN/dmemWEN handshake, waits for dhit, captures
// load data and pulses dHit for one cycle toward the M/WB latch.
// Optional feature macro: MEM_TIMEOUT_EN (bounded BUSY wait, sticky timeout_err).
// Handshake: a request is held constant on dmemREN/dmemWEN/dmemaddr/dmemstore
// from the edge after acceptance until the edge after dhit; dhit completes the
// access in the cycle it is seen; dHit is high for exactly the DONE cycle.
// fsm_state exposes the controller state (0 IDLE, 1 BUSY, 2 DONE, 3 HALTED).
module mem_stage_req_ctrl #(
   parameter int WORD_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ex_memRead,
   input  logic              ex_memWrite,
   input  logic [WORD_W-1:0] ex_addr,
   input  logic [WORD_W-1:0] ex_storeData,
   input  logic              ex_halt,
   input  logic              flush,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore,
   output logic [WORD_W-1:0] dmemLoad,
   output logic              dHit,
   output logic              mem_stall,
   output logic              halted,
   output logic [1:0]        fsm_state
`ifdef MEM_TIMEOUT_EN
   ,
   output logic              timeout_err
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      DONE   = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t state;
   state_t state_nx;
   logic   squash;      // access in flight was flushed; retire silently
   logic   access;
   logic   squash_now;  // includes a flush arriving in the completing cycle
   logic   tmo;
   logic   complete;

   assign access     = (ex_memRead | ex_memWrite) & ~flush;
   assign squash_now = squash | flush;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] busy_cnt;

   // The last permitted BUSY cycle without dhit ends the wait.
   assign tmo = (state == BUSY) && !dhit && (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // BUSY cycle counter and sticky timeout flag.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         busy_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == IDLE && access)
            busy_cnt <= '0;
         else if (state == BUSY && !dhit)
            busy_cnt <= busy_cnt + 1'b1;
         if (tmo)
            timeout_err <= 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
`endif

   assign complete = (state == BUSY) && (dhit || tmo);

   // State register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic; an access in IDLE takes priority over halt.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (access)
               state_nx = BUSY;
            else if (ex_halt && !flush)
               state_nx = HALTED;
         end
         BUSY: begin
            if (complete)
               state_nx = squash_now ? IDLE : DONE;
         end
         DONE:    state_nx = IDLE;
         HALTED:  state_nx = HALTED;
         default: state_nx = IDLE;
      endcase
   end

   // Combinational status outputs derived from state.
   always_comb begin
      mem_stall = 1'b0;
      dHit      = 1'b0;
      halted    = 1'b0;
      fsm_state = state;
      case (state)
         IDLE:    mem_stall = access;
         BUSY:    mem_stall = 1'b1;
         DONE:    dHit      = 1'b1;
         HALTED:  halted    = 1'b1;
         default: mem_stall = 1'b0;
      endcase
   end

   // Request/response datapath: latch on accept, hold through BUSY, capture on completion.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         dmemREN   <= 1'b0;
         dmemWEN   <= 1'b0;
         dmemaddr  <= '0;
         dmemstore <= '0;
         dmemLoad  <= '0;
         squash    <= 1'b0;
      end else begin
         if (state == IDLE && access) begin
            dmemaddr  <= ex_addr;
            dmemstore <= ex_storeData;
            dmemWEN   <= ex_memWrite;
            dmemREN   <= ex_memRead & ~ex_memWrite;
            squash    <= 1'b0;
         end else if (state == BUSY) begin
            if (flush)
               squash <= 1'b1;
            if (complete) begin
               dmemREN <= 1'b0;
               dmemWEN <= 1'b0;
               if (dmemREN && !squash_now)
                  dmemLoad <= dhit ? dmemload : WORD_W'(32'hBAD1BAD1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_req_ctrl.sv
// Bench for mem_stage_req_ctrl: directed vectors, dHit scoreboard on dmemLoad.
module tb_mem_stage_req_ctrl;

   localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2, S_HALT = 2'd3;

   logic        CLK, nRST;
   logic        ex_memRead, ex_memWrite, ex_halt, flush, dhit;
   logic [31:0] ex_addr, ex_storeData, dmemload;
   logic        dmemREN, dmemWEN, dHit, mem_stall, halted;
   logic [31:0] dmemaddr, dmemstore, dmemLoad;
   logic [1:0]  fsm_state;
`ifdef MEM_TIMEOUT_EN
   logic        timeout_err;
`endif

   logic [31:0] exp_q[$];
   logic [31:0] model_load;
   int          n_checks, n_pass;

   mem_stage_req_ctrl #(.WORD_W(32), .TIMEOUT_CYCLES(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
      .ex_addr(ex_addr), .ex_storeData(ex_storeData),
      .ex_halt(ex_halt), .flush(flush),
      .dhit(dhit), .dmemload(dmemload),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .dmemLoad(dmemLoad), .dHit(dHit),
      .mem_stall(mem_stall), .halted(halted),
      .fsm_state(fsm_state)
`ifdef MEM_TIMEOUT_EN
      , .timeout_err(timeout_err)
`endif
   );

   // clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // one step past the active edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      ex_memRead = 0; ex_memWrite = 0; ex_halt = 0; flush = 0; dhit = 0;
      ex_addr = 32'h0; ex_storeData = 32'h0; dmemload = 32'h0;
   endtask

   task automatic do_reset();
      #2 nRST = 1'b0;
      #1;
      model_load = 32'h0;
      tick();
      nRST = 1'b1;
   endtask

   // Issue one access; dhit arrives in BUSY cycle nbusy; flush pulses in BUSY cycle flush_at (0 = none).
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input int nbusy, input logic [31:0] rdata,
                            input int flush_at, input string name);
      logic exp_ren;
      logic squashed;
      exp_ren  = rd & ~wr;
      squashed = (flush_at > 0);
      if (!squashed) begin
         if (exp_ren) model_load = rdata;
         exp_q.push_back(model_load);
      end
      tick();
      ex_memRead = rd; ex_memWrite = wr; ex_addr = a; ex_storeData = d;
      @(negedge CLK);
      check({name, "_req_stall"}, {31'b0, mem_stall}, 32'd1);
      for (int i = 1; i <= nbusy; i++) begin
         tick();
         ex_memRead = 0; ex_memWrite = 0; ex_addr = ~a; ex_storeData = ~d;
         flush = (i == flush_at);
         dhit  = (i == nbusy);
         dmemload = rdata;
         @(negedge CLK);
         check({name, "_busy_ren"},   {31'b0, dmemREN}, {31'b0, exp_ren});
         check({name, "_busy_wen"},   {31'b0, dmemWEN}, {31'b0, wr});
         check({name, "_busy_addr"},  dmemaddr, a);
         check({name, "_busy_store"}, dmemstore, d);
         check({name, "_busy_stall"}, {31'b0, mem_stall}, 32'd1);
      end
      tick();
      dhit = 0; flush = 0; dmemload = 32'h0;
      @(negedge CLK);
      check({name, "_after_ren"}, {30'b0, dmemREN, dmemWEN}, 32'd0);
      check({name, "_after_load"}, dmemLoad, model_load);
      if (!squashed) begin
         check({name, "_done_state"}, {30'b0, fsm_state}, {30'b0, S_DONE});
         check({name, "_done_stall"}, {31'b0, mem_stall}, 32'd0);
         tick();
         @(negedge CLK);
      end
      check({name, "_end_state"}, {30'b0, fsm_state}, {30'b0, S_IDLE});
   endtask

   // scoreboard monitor: every dHit pulse must match the next expected load word
   always @(negedge CLK) begin
      if (nRST && dHit) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_dhit: got dHit=1 load=%h expected no pulse", dmemLoad);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (dmemLoad === e) n_pass++;
            else $display("FAIL dhit_load: got %h expected %h", dmemLoad, e);
         end
      end
   end

   initial begin
      n_checks = 0; n_pass = 0;
      model_load = 32'h0;
      clear_inputs();
      nRST = 1'b0;
      #12;
      check("rst_ren_wen", {30'b0, dmemREN, dmemWEN}, 32'd0);
      check("rst_dhit_halt", {30'b0, dHit, halted}, 32'd0);
      check("rst_addr", dmemaddr, 32'h0);
      check("rst_store", dmemstore, 32'h0);
      check("rst_load", dmemLoad, 32'h0);
      check("rst_state", {30'b0, fsm_state}, {30'b0, S_IDLE});
      tick();
      nRST = 1'b1;

      // load, dhit on third BUSY cycle
      do_access(1, 0, 32'h0000_0040, 32'h0, 3, 32'hDEADBEEF, 0, "load3");
      // store, dhit on first BUSY cycle; dmemLoad stays DEADBEEF
      do_access(0, 1, 32'h0000_0080, 32'h0000_1234, 1, 32'h5555_5555, 0, "store1");
      // read and write together: write wins
      do_access(1, 1, 32'h0000_00C0, 32'hCAFE_F00D, 2, 32'h7777_7777, 0, "rdwr");
      // load flushed in second BUSY cycle, dhit in fourth
      do_access(1, 0, 32'h0000_0044, 32'h0, 4, 32'h1111_2222, 2, "flushld");
      // fresh load afterwards
      do_access(1, 0, 32'h0000_0048, 32'h0, 1, 32'hA5A5_5A5A, 0, "load1");

      // flushed request in IDLE is not accepted; stray dhit in IDLE ignored
      tick();
      ex_memRead = 1; flush = 1; dhit = 1;
      @(negedge CLK);
      check("idle_flush_stall", {31'b0, mem_stall}, 32'd0);
      tick();
      clear_inputs();
      @(negedge CLK);
      check("idle_flush_state", {30'b0, fsm_state}, {30'b0, S_IDLE});
      check("idle_flush_ren", {31'b0, dmemREN}, 32'd0);

      // reset asserted mid-BUSY
      tick();
      ex_memRead = 1; ex_addr = 32'h0000_0100;
      @(negedge CLK);
      tick();
      clear_inputs();
      @(negedge CLK);
      check("mid_busy_ren", {31'b0, dmemREN}, 32'd1);
      #2 nRST = 1'b0;
      #1;
      model_load = 32'h0;
      check("arst_ren", {31'b0, dmemREN}, 32'd0);
      check("arst_state", {30'b0, fsm_state}, {30'b0, S_IDLE});
      check("arst_addr", dmemaddr, 32'h0);
      check("arst_load", dmemLoad, 32'h0);
      check("arst_stall", {31'b0, mem_stall}, 32'd0);
      tick();
      nRST = 1'b1;
      do_access(1, 0, 32'h0000_0104, 32'h0, 2, 32'h0BAD_F00D, 0, "post_rst");

      // halt with no memory op, then requests are ignored
      tick();
      ex_halt = 1;
      @(negedge CLK);
      check("halt_req_stall", {31'b0, mem_stall}, 32'd0);
      tick();
      ex_halt = 0; ex_memRead = 1; ex_addr = 32'h0000_0200;
      @(negedge CLK);
      check("halted_flag", {31'b0, halted}, 32'd1);
      check("halted_state", {30'b0, fsm_state}, {30'b0, S_HALT});
      for (int i = 0; i < 10; i++) begin
         tick();
         dhit = i[0];
         @(negedge CLK);
         check("halted_no_ren", {30'b0, dmemREN, dmemWEN}, 32'd0);
         check("halted_no_stall", {31'b0, mem_stall}, 32'd0);
         check("halted_sticky", {31'b0, halted}, 32'd1);
      end
      clear_inputs();
      do_reset();
      check("halt_cleared", {31'b0, halted}, 32'd0);

`ifdef MEM_TIMEOUT_EN
      // load with dhit never asserted; limit of 4 BUSY cycles
      model_load = 32'hBAD1BAD1;
      exp_q.push_back(model_load);
      tick();
      ex_memRead = 1; ex_addr = 32'h0000_0300;
      @(negedge CLK);
      for (int i = 1; i <= 4; i++) begin
         tick();
         clear_inputs();
         @(negedge CLK);
         check("tmo_busy_ren", {31'b0, dmemREN}, 32'd1);
         check("tmo_busy_err", {31'b0, timeout_err}, 32'd0);
      end
      tick();
      @(negedge CLK);
      check("tmo_err", {31'b0, timeout_err}, 32'd1);
      check("tmo_done_state", {30'b0, fsm_state}, {30'b0, S_DONE});
      check("tmo_ren_drop", {31'b0, dmemREN}, 32'd0);
      tick();
      @(negedge CLK);
      check("tmo_err_sticky", {31'b0, timeout_err}, 32'd1);
      check("tmo_idle", {30'b0, fsm_state}, {30'b0, S_IDLE});
`endif

      tick();
      @(negedge CLK);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // global time bound
   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1);
   end

endmodule
